// File: rtl/pengo_input_conditioner.sv
// rtl/pengo_input_conditioner.sv - sync, debounce, SOCD and frame-locked coin shaping for Pengo inputs
module pengo_input_conditioner #(
  parameter int DEB_TICKS    = 16,
  parameter int COIN_FRAMES  = 4,
  parameter int GUARD_FRAMES = 2
) (
  input  logic       clk_i,
  input  logic       res_n_i,
  input  logic       ce_i,
  input  logic       vblank_i,
  input  logic [7:0] raw_i,
  output logic [7:0] in0_n_o,
  output logic [7:0] in1_n_o,
  output logic [7:0] coin_count_o
);

  localparam int DCW  = (DEB_TICKS > 1) ? $clog2(DEB_TICKS) : 1;
  localparam int FMAX = (COIN_FRAMES > GUARD_FRAMES) ? COIN_FRAMES : GUARD_FRAMES;
  localparam int FCW  = $clog2(FMAX + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PULSE = 2'd1;
  localparam logic [1:0] ST_GUARD = 2'd2;

  logic [7:0]     sync_q1;
  logic [7:0]     sync_q2;
  logic [7:0]     stb;
  logic [DCW-1:0] deb_cnt [8];
  logic           vblank_q;
  logic           stb5_q;
  logic [1:0]     state;
  logic [FCW-1:0] frame_cnt;
  logic           coin_accept;

  logic           vb_rise;
  logic           coin_rise;
  logic           coin_active;
  logic           up_c;
  logic           down_c;
  logic           left_c;
  logic           right_c;

  assign vb_rise     = vblank_i & ~vblank_q;
  assign coin_rise   = stb[5] & ~stb5_q;
  assign coin_active = (state == ST_PULSE);

  // Opposing directions held together cancel each other out.
  assign up_c    = stb[0] & ~stb[1];
  assign down_c  = stb[1] & ~stb[0];
  assign left_c  = stb[2] & ~stb[3];
  assign right_c = stb[3] & ~stb[2];

  // Two-flop synchroniser for the asynchronous control inputs.
  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      sync_q1 <= 8'h00;
      sync_q2 <= 8'h00;
    end else begin
      sync_q1 <= raw_i;
      sync_q2 <= sync_q1;
    end
  end

  // Per-bit debounce: a change must persist DEB_TICKS consecutive ce ticks.
  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      stb <= 8'h00;
      for (int i = 0; i < 8; i++) deb_cnt[i] <= '0;
    end else if (ce_i) begin
      for (int i = 0; i < 8; i++) begin
        if (sync_q2[i] == stb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DCW'(DEB_TICKS - 1)) begin
          stb[i]     <= sync_q2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + DCW'(1);
        end
      end
    end
  end

  // Edge-detect history for vblank and the debounced coin bit.
  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      vblank_q <= 1'b0;
      stb5_q   <= 1'b0;
    end else begin
      vblank_q <= vblank_i;
      stb5_q   <= stb[5];
    end
  end

  // Coin FSM: stretch each accepted coin over whole frames, then hold off re-triggering.
  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      state       <= ST_IDLE;
      frame_cnt   <= '0;
      coin_accept <= 1'b0;
    end else begin
      coin_accept <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (coin_rise) begin
            state       <= ST_PULSE;
            frame_cnt   <= '0;
            coin_accept <= 1'b1;
          end
        end
        ST_PULSE: begin
          if (vb_rise) begin
            if (frame_cnt == FCW'(COIN_FRAMES - 1)) begin
              state     <= ST_GUARD;
              frame_cnt <= '0;
            end else begin
              frame_cnt <= frame_cnt + FCW'(1);
            end
          end
        end
        ST_GUARD: begin
          if (stb[5]) begin
            frame_cnt <= '0;
          end else if (frame_cnt == FCW'(GUARD_FRAMES)) begin
            state     <= ST_IDLE;
            frame_cnt <= '0;
          end else if (vb_rise) begin
            frame_cnt <= frame_cnt + FCW'(1);
          end
        end
        default: begin
          state     <= ST_IDLE;
          frame_cnt <= '0;
        end
      endcase
    end
  end

  // Registered active-low outputs and saturating coin counter.
  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      in0_n_o      <= 8'hFF;
      in1_n_o      <= 8'hFF;
      coin_count_o <= 8'h00;
    end else begin
      in0_n_o <= ~{stb[4], 1'b0, 1'b0, coin_active, right_c, left_c, down_c, up_c};
      in1_n_o <= ~{1'b0, stb[7], stb[6], 5'b00000};
      if (coin_accept && (coin_count_o != 8'hFF)) begin
        coin_count_o <= coin_count_o + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_pengo_input_conditioner.sv
// tb/tb_pengo_input_conditioner.sv - scoreboard bench for pengo_input_conditioner
module tb_pengo_input_conditioner;

  localparam int DEB = 4;
  localparam int CF  = 4;
  localparam int GF  = 2;

  logic       clk      = 1'b0;
  logic       res_n_i  = 1'b0;
  logic       ce_i     = 1'b0;
  logic       vblank_i = 1'b0;
  logic [7:0] raw_i    = 8'h00;
  logic [7:0] in0_n_o;
  logic [7:0] in1_n_o;
  logic [7:0] coin_count_o;

  always #5 clk = ~clk;

  pengo_input_conditioner #(
    .DEB_TICKS   (DEB),
    .COIN_FRAMES (CF),
    .GUARD_FRAMES(GF)
  ) dut (
    .clk_i       (clk),
    .res_n_i     (res_n_i),
    .ce_i        (ce_i),
    .vblank_i    (vblank_i),
    .raw_i       (raw_i),
    .in0_n_o     (in0_n_o),
    .in1_n_o     (in1_n_o),
    .coin_count_o(coin_count_o)
  );

  typedef struct packed {
    logic [7:0] in0;
    logic [7:0] in1;
    logic [7:0] cnt;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;

  logic [7:0] raw_v     = 8'h00;
  logic       rst_v     = 1'b0;
  int         cyc       = 0;
  int         vb_ph     = 0;
  int         vb_period = 400;

  // reference model state
  logic [7:0] m_h1, m_h2, m_stb;
  int         m_run [8];
  logic       m_stb5q, m_vbq, m_acc;
  int         m_phase, m_left, m_quiet, m_cnt;

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", name, got, want, $time);
    end
  endtask

  task automatic model_reset();
    m_h1 = 8'h00; m_h2 = 8'h00; m_stb = 8'h00;
    for (int i = 0; i < 8; i++) m_run[i] = 0;
    m_stb5q = 1'b0; m_vbq = 1'b0; m_acc = 1'b0;
    m_phase = 0; m_left = 0; m_quiet = 0; m_cnt = 0;
  endtask

  // Drive one clock of stimulus and push the outputs expected after the next edge.
  task automatic cycle();
    logic [7:0] st;
    logic up, dn, lf, rt, vbr, cr, nacc;
    exp_t e;
    @(negedge clk);
    cyc++;
    vb_ph    = (vb_ph + 1) % vb_period;
    ce_i     = (cyc % 4 == 0);
    vblank_i = (vb_ph < 3);
    raw_i    = raw_v;
    res_n_i  = rst_v;
    if (!rst_v) begin
      model_reset();
      e = {8'hFF, 8'hFF, 8'h00};
    end else begin
      st = m_stb;
      up = st[0] & ~st[1];
      dn = st[1] & ~st[0];
      lf = st[2] & ~st[3];
      rt = st[3] & ~st[2];
      e.in0 = ~{st[4], 2'b00, (m_phase == 1), rt, lf, dn, up};
      e.in1 = ~{1'b0, st[7], st[6], 5'b00000};
      if (m_acc && m_cnt < 255) m_cnt++;
      e.cnt = 8'(m_cnt);
      vbr  = vblank_i & ~m_vbq;
      cr   = st[5] & ~m_stb5q;
      nacc = (m_phase == 0) && cr;
      case (m_phase)
        0: if (cr) begin m_phase = 1; m_left = CF; end
        1: if (vbr) begin
             m_left--;
             if (m_left == 0) begin m_phase = 2; m_quiet = 0; end
           end
        default: begin
          if (st[5]) m_quiet = 0;
          else if (m_quiet >= GF) m_phase = 0;
          else if (vbr) m_quiet++;
        end
      endcase
      m_acc   = nacc;
      m_stb5q = st[5];
      m_vbq   = vblank_i;
      if (ce_i) begin
        for (int i = 0; i < 8; i++) begin
          if (m_h2[i] != st[i]) begin
            m_run[i]++;
            if (m_run[i] == DEB) begin m_stb[i] = m_h2[i]; m_run[i] = 0; end
          end else begin
            m_run[i] = 0;
          end
        end
      end
      m_h2 = m_h1;
      m_h1 = raw_v;
    end
    sbq.push_back(e);
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  // Monitor: pop the expected response for every presented output cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        if (bad < 40) begin
          check("sb_in0", in0_n_o, e.in0);
          check("sb_in1", in1_n_o, e.in1);
          check("sb_cnt", coin_count_o, e.cnt);
        end
      end
    end
  end

  initial begin
    bit seen;
    model_reset();
    // 1: reset then idle
    rst_v = 1'b0; raw_v = 8'h00;
    run(6);
    rst_v = 1'b1;
    run(200);
    check("idle_in0", in0_n_o, 8'hFF);
    check("idle_in1", in1_n_o, 8'hFF);
    check("idle_cnt", coin_count_o, 8'h00);

    // 2: short glitch rejected, long hold accepted
    raw_v = 8'h01; run(12);
    raw_v = 8'h00; run(40);
    check("glitch_in0", in0_n_o, 8'hFF);
    raw_v = 8'h01; run(40);
    check("hold_up_in0", in0_n_o, 8'hFE);
    raw_v = 8'h00; run(40);

    // 3: SOCD up+down+left
    raw_v = 8'h07; run(60);
    check("socd_in0", in0_n_o, 8'hFB);
    raw_v = 8'hC0; run(60);
    check("start_in1", in1_n_o, 8'h9F);
    raw_v = 8'h00; run(60);

    // random stimulus at a faster frame rate
    vb_period = 40;
    for (int s = 0; s < 150; s++) begin
      raw_v = 8'($urandom);
      run($urandom_range(1, 40));
    end
    raw_v = 8'h00; run(400);
    rst_v = 1'b0; run(3); rst_v = 1'b1; run(10);

    // 4: coin held for 50 frames, second press during guard ignored
    vb_period = 400;
    raw_v = 8'h20; run(50 * 400);
    raw_v = 8'h00; run(100);
    raw_v = 8'h20; run(100);
    raw_v = 8'h00; run(1200);
    check("single_coin_cnt", coin_count_o, 8'd1);
    check("single_coin_in0", in0_n_o, 8'hFF);

    // 5: counter saturation
    vb_period = 12;
    for (int c = 0; c < 260; c++) begin
      raw_v = 8'h20; run(30);
      raw_v = 8'h00; run(90);
    end
    check("sat_cnt", coin_count_o, 8'hFF);

    // 6: reset during a coin pulse
    vb_period = 400;
    raw_v = 8'h20;
    seen = 1'b0;
    for (int w = 0; w < 500 && !seen; w++) begin
      cycle();
      if (in0_n_o[4] == 1'b0) seen = 1'b1;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL pulse_wait got=timeout want=coin_low");
    end
    rst_v = 1'b0;
    cycle();
    #1;
    check("async_rst_in0", in0_n_o, 8'hFF);
    check("async_rst_cnt", coin_count_o, 8'h00);
    raw_v = 8'h00;
    run(4);
    rst_v = 1'b1;
    run(100);
    check("post_rst_cnt", coin_count_o, 8'h00);

    @(posedge clk);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
